// File: rtl/rv32i_defs.sv
// RV32I shared definitions: widths, ALU/operand/writeback codes,
// branch conditions and the ID/EX, EX/MEM pipeline bundles.
package rv32i_defs;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          src_a;
    logic                src_b_imm;
    logic                branch;
    logic                jal;
    logic                jalr;
    logic [2:0]          funct3;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [1:0]          wb_sel;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [1:0]      wb_sel;
  } ex_mem_t;

  function automatic logic br_cond(
    input logic [2:0]      f3,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic r;
    r = 1'b0;
    case (f3)
      F3_BEQ:  r = (a == b);
      F3_BNE:  r = (a != b);
      F3_BLT:  r = ($signed(a) < $signed(b));
      F3_BGE:  r = ($signed(a) >= $signed(b));
      F3_BLTU: r = (a < b);
      F3_BGEU: r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational RV32I ALU; shifts use B[4:0], unknown ops give zero.
module ex_alu
  import rv32i_defs::*;
(
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [XLEN-1:0]     res_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  // Operation select
  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:    res_o = a_i + b_i;
      ALU_SUB:    res_o = a_i - b_i;
      ALU_SLL:    res_o = a_i << shamt;
      ALU_SLT:    res_o = {{(XLEN-1){1'b0}},
                           $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   res_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_XOR:    res_o = a_i ^ b_i;
      ALU_SRL:    res_o = a_i >> shamt;
      ALU_SRA:    res_o = $signed(a_i) >>> shamt;
      ALU_OR:     res_o = a_i | b_i;
      ALU_AND:    res_o = a_i & b_i;
      ALU_PASS_B: res_o = b_i;
      default:    res_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: ID/EX register, forwarding, ALU, branch/jump
// resolution and EX/MEM register.
module execute_stage
  import rv32i_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [1:0]          id_src_a,
  input  logic                id_src_b_imm,
  input  logic                id_branch,
  input  logic                id_jal,
  input  logic                id_jalr,
  input  logic [2:0]          id_funct3,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic [1:0]          id_wb_sel,
  input  logic                stall,
  input  logic                flush,
  input  logic [1:0]          fwda_select,
  input  logic [1:0]          fwdb_select,
  input  logic [XLEN-1:0]     mem_fwd_data,
  input  logic [XLEN-1:0]     wb_fwd_data,
  output logic [4:0]          ex_rs1,
  output logic [4:0]          ex_rs2,
  output logic                is_branch,
  output logic                jum,
  output logic [XLEN-1:0]     target_pc,
  output logic                mem_valid,
  output logic [XLEN-1:0]     mem_alu_result,
  output logic [XLEN-1:0]     mem_store_data,
  output logic [XLEN-1:0]     mem_pc_plus4,
  output logic [4:0]          mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic [2:0]          mem_funct3,
  output logic [1:0]          mem_wb_sel
);

  id_ex_t          ex_q, ex_d;
  ex_mem_t         mem_q, mem_d;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] alu_res;
  logic            cond;

  // ID/EX next state: a flush or stall (or both) inserts one bubble
  always_comb begin
    ex_d = '0;
    if (!(flush || stall)) begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.alu_op    = id_alu_op;
      ex_d.src_a     = id_src_a;
      ex_d.src_b_imm = id_src_b_imm;
      ex_d.branch    = id_branch;
      ex_d.jal       = id_jal;
      ex_d.jalr      = id_jalr;
      ex_d.funct3    = id_funct3;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
      ex_d.wb_sel    = id_wb_sel;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // Forwarding muxes; select 11 falls back to the regfile value
  always_comb begin
    fwd_a = ex_q.rs1_data;
    fwd_b = ex_q.rs2_data;
    case (fwda_select)
      FWD_MEM: fwd_a = mem_fwd_data;
      FWD_WB:  fwd_a = wb_fwd_data;
      default: fwd_a = ex_q.rs1_data;
    endcase
    case (fwdb_select)
      FWD_MEM: fwd_b = mem_fwd_data;
      FWD_WB:  fwd_b = wb_fwd_data;
      default: fwd_b = ex_q.rs2_data;
    endcase
  end

  // ALU operand selection
  always_comb begin
    op_a = '0;
    case (ex_q.src_a)
      SRC_A_RS1: op_a = fwd_a;
      SRC_A_PC:  op_a = ex_q.pc;
      default:   op_a = '0;
    endcase
    op_b = ex_q.src_b_imm ? ex_q.imm : fwd_b;
  end

  ex_alu u_alu (
    .op_i  (ex_q.alu_op),
    .a_i   (op_a),
    .b_i   (op_b),
    .res_o (alu_res)
  );

  assign cond      = br_cond(ex_q.funct3, fwd_a, fwd_b);
  assign is_branch = ex_q.valid & ex_q.branch & cond;
  assign jum       = ex_q.valid & (ex_q.jal | ex_q.jalr);
  assign ex_rs1    = ex_q.rs1;
  assign ex_rs2    = ex_q.rs2;

  // Redirect target; JALR clears bit 0
  always_comb begin
    if (ex_q.jalr) target_pc = (fwd_a + ex_q.imm) & ~XLEN'(1);
    else           target_pc = ex_q.pc + ex_q.imm;
  end

  // EX/MEM next state; side effects only for valid instructions
  always_comb begin
    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.alu_result = alu_res;
    mem_d.store_data = fwd_b;
    mem_d.pc_plus4   = ex_q.pc + XLEN'(4);
    mem_d.rd         = ex_q.rd;
    mem_d.reg_write  = ex_q.valid & ex_q.reg_write;
    mem_d.mem_read   = ex_q.valid & ex_q.mem_read;
    mem_d.mem_write  = ex_q.valid & ex_q.mem_write;
    mem_d.funct3     = ex_q.funct3;
    mem_d.wb_sel     = ex_q.wb_sel;
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign mem_valid      = mem_q.valid;
  assign mem_alu_result = mem_q.alu_result;
  assign mem_store_data = mem_q.store_data;
  assign mem_pc_plus4   = mem_q.pc_plus4;
  assign mem_rd         = mem_q.rd;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_funct3     = mem_q.funct3;
  assign mem_wb_sel     = mem_q.wb_sel;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases plus random
// instruction streams checked against a behavioural model.
module tb_execute_stage;
  import rv32i_defs::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic [1:0]  srca;
    logic        srcbimm, br, jal, jalr;
    logic [2:0]  f3;
    logic        rw, mr, mw;
    logic [1:0]  wb;
  } ins_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu, sd, pc4;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic [1:0]  wb;
  } exp_t;

  logic        clk = 0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_src_a;
  logic        id_src_b_imm, id_branch, id_jal, id_jalr;
  logic [2:0]  id_funct3;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [1:0]  id_wb_sel;
  logic        stall, flush;
  logic [1:0]  fwda_select, fwdb_select;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [4:0]  ex_rs1, ex_rs2;
  logic        is_branch, jum;
  logic [31:0] target_pc;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_store_data, mem_pc_plus4;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_wb_sel;

  execute_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_alu_op(id_alu_op), .id_src_a(id_src_a),
    .id_src_b_imm(id_src_b_imm), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_funct3(id_funct3),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_wb_sel(id_wb_sel),
    .stall(stall), .flush(flush), .fwda_select(fwda_select),
    .fwdb_select(fwdb_select), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .is_branch(is_branch), .jum(jum), .target_pc(target_pc),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_pc_plus4(mem_pc_plus4),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_funct3(mem_funct3), .mem_wb_sel(mem_wb_sel)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  ins_t ex_m;
  logic obs_br, obs_jum;
  logic [31:0] obs_tgt;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  function automatic logic [31:0] alu_m(input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic cond_m(input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 3));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int   k;
    i = '0;
    if ($urandom_range(0, 9) == 0) return i;
    i.valid = 1'b1;
    i.pc = $urandom & 32'hFFFF_FFFC;
    i.rs1d = pick();
    i.rs2d = pick();
    i.imm = pick();
    i.rs1 = 5'($urandom);
    i.rs2 = 5'($urandom);
    i.rd = 5'($urandom);
    i.op = 4'($urandom);
    i.srca = 2'($urandom);
    i.srcbimm = 1'($urandom);
    k = $urandom_range(0, 7);
    i.br = (k < 2);
    i.jal = (k == 2);
    i.jalr = (k == 3);
    i.f3 = 3'($urandom);
    i.rw = 1'($urandom);
    i.mr = 1'($urandom);
    i.mw = 1'($urandom);
    i.wb = 2'($urandom_range(0, 2));
    return i;
  endfunction

  task automatic drive_id(input ins_t i);
    id_valid = i.valid;      id_pc = i.pc;
    id_rs1_data = i.rs1d;    id_rs2_data = i.rs2d;
    id_imm = i.imm;          id_rs1 = i.rs1;
    id_rs2 = i.rs2;          id_rd = i.rd;
    id_alu_op = i.op;        id_src_a = i.srca;
    id_src_b_imm = i.srcbimm; id_branch = i.br;
    id_jal = i.jal;          id_jalr = i.jalr;
    id_funct3 = i.f3;        id_reg_write = i.rw;
    id_mem_read = i.mr;      id_mem_write = i.mw;
    id_wb_sel = i.wb;
  endtask

  // One clock: new ID instruction plus forwarding for the one in EX.
  task automatic cycle(input ins_t nid, input logic st,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [31:0] mfd, input logic [31:0] wfd);
    logic [31:0] a_v, b_v, opa, opb, tgt;
    logic        tk, jp;
    exp_t        e;
    a_v = (fa == 2'b01) ? mfd : (fa == 2'b10) ? wfd : ex_m.rs1d;
    b_v = (fb == 2'b01) ? mfd : (fb == 2'b10) ? wfd : ex_m.rs2d;
    opa = (ex_m.srca == 2'b00) ? a_v :
          (ex_m.srca == 2'b01) ? ex_m.pc : 32'd0;
    opb = ex_m.srcbimm ? ex_m.imm : b_v;
    tk  = ex_m.valid && ex_m.br && cond_m(ex_m.f3, a_v, b_v);
    jp  = ex_m.valid && (ex_m.jal || ex_m.jalr);
    tgt = ex_m.jalr ? ((a_v + ex_m.imm) & 32'hFFFF_FFFE)
                    : ex_m.pc + ex_m.imm;
    e = '0;
    e.valid = ex_m.valid;
    e.alu = alu_m(ex_m.op, opa, opb);
    e.sd  = b_v;
    e.pc4 = ex_m.pc + 32'd4;
    e.rd  = ex_m.rd;
    e.rw  = ex_m.valid & ex_m.rw;
    e.mr  = ex_m.valid & ex_m.mr;
    e.mw  = ex_m.valid & ex_m.mw;
    e.f3  = ex_m.f3;
    e.wb  = ex_m.wb;
    fwda_select = fa;  fwdb_select = fb;
    mem_fwd_data = mfd; wb_fwd_data = wfd;
    flush = tk | jp;
    stall = st;
    drive_id(nid);
    @(negedge clk);
    obs_br = is_branch; obs_jum = jum; obs_tgt = target_pc;
    chk("is_branch", 32'(is_branch), 32'(tk));
    chk("jum", 32'(jum), 32'(jp));
    if (tk || jp) chk("target_pc", target_pc, tgt);
    chk("ex_rs1", 32'(ex_rs1), 32'(ex_m.rs1));
    chk("ex_rs2", 32'(ex_rs2), 32'(ex_m.rs2));
    @(posedge clk);
    exp_q.push_back(e);
    ex_m = (tk || jp || st) ? '0 : nid;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_alu", mem_alu_result, 32'd0);
    chk("rst_mem_pc4", mem_pc_plus4, 32'd0);
    chk("rst_mem_side", {29'd0, mem_reg_write, mem_mem_read,
        mem_mem_write}, 32'd0);
    chk("rst_br_jum", {30'd0, is_branch, jum}, 32'd0);
    chk("rst_ex_rs", {22'd0, ex_rs1, ex_rs2}, 32'd0);
    rst = 1'b0;
    ex_m = '0;
  endtask

  // Monitor: every EX/MEM output is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mem_valid", 32'(mem_valid), 32'(e.valid));
      chk("mem_side", {29'd0, mem_reg_write, mem_mem_read,
          mem_mem_write}, {29'd0, e.rw, e.mr, e.mw});
      if (e.valid) begin
        chk("mem_alu_result", mem_alu_result, e.alu);
        chk("mem_store_data", mem_store_data, e.sd);
        chk("mem_pc_plus4", mem_pc_plus4, e.pc4);
        chk("mem_ctl", {22'd0, mem_rd, mem_funct3, mem_wb_sel},
            {22'd0, e.rd, e.f3, e.wb});
      end
    end
  end

  initial begin
    ins_t t, t2, z;
    z = '0;
    ex_m = '0;
    fwda_select = 0; fwdb_select = 0;
    mem_fwd_data = 0; wb_fwd_data = 0;
    drive_id(z);
    do_reset();

    // forwarding MEM + WB into ADD
    t = z; t.valid = 1; t.op = ALU_ADD; t.rs1d = 32'hAAAA;
    t.rs2d = 32'hBBBB; t.rd = 5; t.rw = 1;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(z, 0, 2'b01, 2'b10, 32'h10, 32'h5);
    chk("fwd_add", mem_alu_result, 32'h15);
    t.rs1d = 32'h7; t.rs2d = 32'h3;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(z, 0, 2'b11, 2'b11, 32'h100, 32'h200);
    chk("fwd_sel11", mem_alu_result, 32'hA);

    // BLT taken, BLTU not taken
    t = z; t.valid = 1; t.br = 1; t.f3 = 3'b100; t.pc = 32'h100;
    t.imm = 32'h20; t.rs1d = 32'hFFFF_FFFF; t.rs2d = 32'h1;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(z, 0, 0, 0, 0, 0);
    chk("blt_taken", 32'(obs_br), 32'd1);
    chk("blt_target", obs_tgt, 32'h120);
    t.f3 = 3'b110;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(z, 0, 0, 0, 0, 0);
    chk("bltu_not_taken", 32'(obs_br), 32'd0);

    // JALR with younger instruction squashed
    t = z; t.valid = 1; t.jalr = 1; t.rs1d = 32'h1003; t.pc = 32'h40;
    t.wb = 2'b10; t.rw = 1; t.rd = 1;
    t2 = z; t2.valid = 1; t2.rw = 1; t2.rd = 7;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(t2, 0, 0, 0, 0, 0);
    chk("jalr_jum", 32'(obs_jum), 32'd1);
    chk("jalr_target", obs_tgt, 32'h1002);
    chk("jalr_pc4", mem_pc_plus4, 32'h44);
    chk("jalr_wb", {30'd0, mem_wb_sel}, 32'h2);
    chk("jalr_rw", 32'(mem_reg_write), 32'd1);
    cycle(z, 0, 0, 0, 0, 0);
    chk("jalr_young_bubble", {30'd0, mem_valid, mem_reg_write}, 32'd0);

    // stall bubble, then flush+stall gives exactly one bubble
    cycle(t2, 1, 0, 0, 0, 0);
    cycle(z, 0, 0, 0, 0, 0);
    chk("stall_bubble", {30'd0, mem_valid, mem_reg_write}, 32'd0);
    t = z; t.valid = 1; t.jal = 1; t.pc = 32'h200; t.imm = 32'h8;
    t.rw = 1; t.wb = 2'b10;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(t2, 1, 0, 0, 0, 0);
    t2.rd = 9;
    cycle(t2, 0, 0, 0, 0, 0);
    chk("fs_one_bubble", 32'(mem_valid), 32'd0);
    cycle(z, 0, 0, 0, 0, 0);
    chk("fs_next_valid", {26'd0, mem_valid, mem_rd}, {26'd0, 1'b1, 5'd9});

    // SRA uses B[4:0]; SUB wraps
    t = z; t.valid = 1; t.op = ALU_SRA; t.rs1d = 32'h8000_0000;
    t.srcbimm = 1; t.imm = 32'h21;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(z, 0, 0, 0, 0, 0);
    chk("sra", mem_alu_result, 32'hC000_0000);
    t = z; t.valid = 1; t.op = ALU_SUB; t.rs1d = 0; t.rs2d = 1;
    cycle(t, 0, 0, 0, 0, 0);
    cycle(z, 0, 0, 0, 0, 0);
    chk("sub", mem_alu_result, 32'hFFFF_FFFF);

    // random stream, mid-stream reset, more random
    for (int i = 0; i < 400; i++)
      cycle(rnd_ins(), ($urandom_range(0, 4) == 0),
            2'($urandom), 2'($urandom), pick(), pick());
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle(rnd_ins(), ($urandom_range(0, 4) == 0),
            2'($urandom), 2'($urandom), pick(), pick());

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
